// File: rtl/imuldiv_div_initiator_pkg.sv
// rtl/imuldiv_div_initiator_pkg.sv - shared encodings and tag layout for the divide initiator
//
// Holds the divider fn encodings, the quotient/remainder select encodings,
// the divide-by-zero quotient value and the tag FIFO entry layout.
package imuldiv_div_initiator_pkg;

    localparam int DATA_W = 32;
    localparam int RESP_W = 2 * DATA_W;

    // Divider request fn field
    localparam logic DIVREQ_FN_SIGNED   = 1'b0;
    localparam logic DIVREQ_FN_UNSIGNED = 1'b1;

    // Which half of the divider response is returned to the core
    localparam logic SEL_QUOT = 1'b0;
    localparam logic SEL_REM  = 1'b1;

    // Quotient returned for any divide by zero, signed or unsigned
    localparam logic [DATA_W-1:0] DZ_QUOTIENT = 32'hFFFF_FFFF;

    // One tag per accepted command. The dividend is kept so a divide by
    // zero can return it as the remainder without asking the divider.
    typedef struct packed {
        logic              sel;
        logic              dz;
        logic [DATA_W-1:0] a;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

    // Result for a command that went through the divider
    function automatic logic [DATA_W-1:0] select_result(
        input logic              sel,
        input logic [RESP_W-1:0] result
    );
        return (sel == SEL_REM) ? result[RESP_W-1:DATA_W] : result[DATA_W-1:0];
    endfunction

    // Result for a command whose divisor was zero
    function automatic logic [DATA_W-1:0] dz_result(
        input logic              sel,
        input logic [DATA_W-1:0] a
    );
        return (sel == SEL_QUOT) ? DZ_QUOTIENT : a;
    endfunction

endpackage

// File: rtl/imuldiv_tag_fifo.sv
// rtl/imuldiv_tag_fifo.sv - small in-order tag FIFO for outstanding divide commands
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   push, push_data   write one entry (ignored when full)
//   pop               drop the head entry (ignored when empty)
//   head              current head entry (meaningless when empty)
//   empty             no entries held
//   count             number of entries held, 0..DEPTH
module imuldiv_tag_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 34
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while count says valid
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/imuldiv_div_initiator.sv
// rtl/imuldiv_div_initiator.sv - requester front end for the integer divide unit
//
// Ports:
//   clk, reset                   clock, asynchronous active-low reset
//   cmd_val/cmd_rdy              command handshake
//   cmd_fn, cmd_sel              0/1 = signed/unsigned, 0/1 = quotient/remainder
//   cmd_a, cmd_b                 dividend, divisor
//   divreq_val/divreq_rdy        request handshake to the divider
//   divreq_msg_fn/_a/_b          registered divider request
//   divresp_val/divresp_rdy      response handshake from the divider
//   divresp_msg_result           {remainder, quotient}
//   res_val/res_rdy, res_data    one 32-bit result per command, in order
module imuldiv_div_initiator
    import imuldiv_div_initiator_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_val,
    output logic              cmd_rdy,
    input  logic              cmd_fn,
    input  logic              cmd_sel,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic              divreq_msg_fn,
    output logic [DATA_W-1:0] divreq_msg_a,
    output logic [DATA_W-1:0] divreq_msg_b,
    output logic              divreq_val,
    input  logic              divreq_rdy,
    input  logic [RESP_W-1:0] divresp_msg_result,
    input  logic              divresp_val,
    output logic              divresp_rdy,
    output logic              res_val,
    input  logic              res_rdy,
    output logic [DATA_W-1:0] res_data
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             req_full;
    logic             res_full;
    logic             cmd_fire;
    logic             cmd_dz;
    tag_t             push_tag;
    tag_t             head_tag;
    logic             tag_empty;
    logic [CNT_W-1:0] tag_count;
    logic             head_valid;
    logic             can_load;
    logic             resp_fire;
    logic             dz_retire;
    logic             res_load;
    logic [DATA_W-1:0] load_data;

    // Command side. Built from registered state only, so a pop while the
    // FIFO is full frees a slot one cycle later. Held low during reset.
    assign cmd_rdy  = reset && !req_full && (tag_count < CNT_W'(DEPTH));
    assign cmd_fire = cmd_val && cmd_rdy;
    assign cmd_dz   = (cmd_b == '0);

    assign push_tag.sel = cmd_sel;
    assign push_tag.dz  = cmd_dz;
    assign push_tag.a   = cmd_a;

    imuldiv_tag_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TAG_W)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cmd_fire),
        .push_data (push_tag),
        .pop       (res_load),
        .head      (head_tag),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    // Request register: divide-by-zero commands never load it
    assign divreq_val = req_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_full      <= 1'b0;
            divreq_msg_fn <= 1'b0;
            divreq_msg_a  <= '0;
            divreq_msg_b  <= '0;
        end else begin
            if (divreq_val && divreq_rdy) begin
                req_full <= 1'b0;
            end
            // cmd_rdy requires an empty request register, so this never
            // collides with the clear above
            if (cmd_fire && !cmd_dz) begin
                req_full      <= 1'b1;
                divreq_msg_fn <= cmd_fn;
                divreq_msg_a  <= cmd_a;
                divreq_msg_b  <= cmd_b;
            end
        end
    end

    // Result side. A dz head retires on its own; otherwise the head waits
    // for the next divider response, which is always its own because the
    // divider answers in order and only non-dz tags send requests.
    assign head_valid  = !tag_empty;
    assign can_load    = !res_full || res_rdy;
    assign divresp_rdy = can_load && head_valid && !head_tag.dz;
    assign resp_fire   = divresp_val && divresp_rdy;
    assign dz_retire   = can_load && head_valid && head_tag.dz;
    assign res_load    = resp_fire || dz_retire;

    assign load_data = head_tag.dz ? dz_result(head_tag.sel, head_tag.a)
                                   : select_result(head_tag.sel, divresp_msg_result);

    assign res_val = res_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_full <= 1'b0;
            res_data <= '0;
        end else if (res_load) begin
            res_full <= 1'b1;
            res_data <= load_data;
        end else if (res_val && res_rdy) begin
            res_full <= 1'b0;
        end
    end

endmodule
